// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin arbiter in front of one shared combinational ALU
// Define ALU_ARB_FIXED_PRIO_EN to make port 0 always win on contention (no pointer).
module alu_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_z
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state;
  state_t     state_nxt;
  logic       owner;
  logic [1:0] grant;
  logic       accept;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) grant = 2'b01;
  end
`else
  // last_grant resets to 1 so port 0 is favoured first
  logic last_grant;

  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant <= 1'b1;
    else if (accept) last_grant <= grant[1];
  end
`endif

  always_comb begin
    state_nxt  = state;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    case (state)
      IDLE: begin
        req_ready = grant;
        if (|grant) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        resp_valid = owner ? 2'b10 : 2'b01;
        if (resp_ready[owner]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && (|grant);

  // The ALU operand registers double as the captured request, so they hold between ops
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      alu_op      <= 3'b000;
      alu_a       <= '0;
      alu_b       <= '0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner  <= grant[1];
        alu_op <= grant[1] ? req_op1 : req_op0;
        alu_a  <= grant[1] ? req_a1  : req_a0;
        alu_b  <= grant[1] ? req_b1  : req_b0;
      end
      if (state == EXEC) begin
        resp_result <= alu_res;
        resp_zero   <= alu_z;
      end
    end
  end

endmodule
